// File: rtl/adc_pkg.sv
// Shared types, defaults and sample conversion for the ADC
// ping-pong frame buffer.
package adc_pkg;

  localparam int ADC_DATA_W    = 12;
  localparam int ADC_FRAME_LEN = 64;

  typedef enum logic {
    W_FILL,
    W_FULL
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PRIME,
    R_STREAM
  } rd_state_t;

  // Offset-binary to two's complement: flip the sign bit.
  function automatic logic [31:0] offset_to_signed(
    input logic [31:0] code,
    input int unsigned width
  );
    return code ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/adc_frame_buffer_ram.sv
// Simple dual-port RAM holding both frame banks; registered read
// with read enable so the output word holds while idle.
module frame_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_frame_buffer.sv
// ADC ping-pong frame buffer: fills one bank from the ADC strobe
// while the other bank streams out as a valid/ready frame.
module adc_frame_buffer
  import adc_pkg::*;
#(
  parameter int DATA_W    = ADC_DATA_W,
  parameter int FRAME_LEN = ADC_FRAME_LEN,
  parameter int DROP_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  output logic [DROP_W-1:0] dropped,
  output logic [15:0]       frames_out
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  wr_state_t         wr_state;
  rd_state_t         rd_state;
  logic              wr_bank;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              fetch_done;
  logic              pf_valid;
  logic              pf_last;
  logic              swap;
  logic              we;
  logic              re;
  logic              drop;
  logic              load;
  logic              hs;
  logic [IDX_W:0]    waddr;
  logic [IDX_W:0]    raddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  assign swap  = (wr_state == W_FULL) && (rd_state == R_IDLE);
  assign we    = in_valid && ((wr_state == W_FILL) || swap);
  assign drop  = in_valid && !we;
  assign waddr = swap ? {~wr_bank, {IDX_W{1'b0}}}
                      : {wr_bank, wr_idx};
  assign wdata = DATA_W'(offset_to_signed(32'(in_data), DATA_W));

  // rdata doubles as the prefetch slot: it only advances when
  // the output register takes its word, so stalls lose nothing.
  assign hs    = out_valid && out_ready;
  assign load  = pf_valid && (!out_valid || out_ready);
  assign re    = swap
              || ((rd_state != R_IDLE) && !fetch_done
                  && (!pf_valid || load));
  assign raddr = swap ? {wr_bank, {IDX_W{1'b0}}}
                      : {~wr_bank, rd_idx};

  frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (IDX_W + 1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state <= W_FILL;
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      overflow <= drop;
      if (drop && (dropped != '1))
        dropped <= dropped + DROP_W'(1);
      if (swap) begin
        wr_bank  <= ~wr_bank;
        wr_idx   <= in_valid ? IDX_W'(1) : '0;
        wr_state <= W_FILL;
      end else if (we) begin
        wr_idx <= wr_idx + IDX_W'(1);
        if (wr_idx == LAST) wr_state <= W_FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state   <= R_IDLE;
      rd_idx     <= '0;
      fetch_done <= 1'b0;
      pf_valid   <= 1'b0;
      pf_last    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frames_out <= '0;
    end else begin
      if (swap) begin
        rd_idx     <= IDX_W'(1);
        fetch_done <= 1'b0;
        pf_last    <= 1'b0;
      end else if (re) begin
        rd_idx     <= rd_idx + IDX_W'(1);
        fetch_done <= (rd_idx == LAST);
        pf_last    <= (rd_idx == LAST);
      end
      if (re)
        pf_valid <= 1'b1;
      else if (load)
        pf_valid <= 1'b0;
      if (load) begin
        out_data <= rdata;
        out_last <= pf_last;
      end
      unique case (rd_state)
        R_IDLE:
          if (swap) rd_state <= R_PRIME;
        R_PRIME: begin
          rd_state  <= R_STREAM;
          out_valid <= 1'b1;
        end
        R_STREAM:
          if (hs && out_last) begin
            rd_state   <= R_IDLE;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frames_out <= frames_out + 16'd1;
          end
        default:
          rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Scoreboard bench for adc_frame_buffer with FRAME_LEN = 8:
// stimulus pushes expected words, a negedge monitor pops them.
module tb_adc_frame_buffer;

  localparam int DW  = 12;
  localparam int FL  = 8;
  localparam int DRW = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_last;
  logic           overflow;
  logic [DRW-1:0] dropped;
  logic [15:0]    frames_out;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            gaps[$];
  int            compared = 0;
  int            mismatched = 0;
  int            cyc = 0;
  int            ovf_cnt = 0;
  int            n_pushed = 0;
  int            rdy_mode = 1;
  int            first_valid = -1;
  int            last_strobe = -1;
  int            last_hs = -1;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] held_d;
  logic          held_l;

  adc_frame_buffer #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .DROP_W    (DRW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .dropped    (dropped),
    .frames_out (frames_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (overflow) ovf_cnt++;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (last_hs >= 0) begin
          gaps.push_back(cyc - last_hs);
          last_hs = -1;
        end
        if (stall_prev) begin
          chk("hold_data", 32'(out_data), 32'(held_d));
          chk("hold_last", 32'(out_last), 32'(held_l));
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_out: got 0x%0h, expected none",
                     out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_last", 32'(out_last), 32'(e.l));
          end
          if (out_last) last_hs = cyc + 1;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held_d = out_data;
          held_l = out_last;
        end
      end else begin
        if (stall_prev) begin
          compared++;
          mismatched++;
          $display("FAIL valid_dropped: got 0, expected 1");
        end
        stall_prev = 1'b0;
      end
    end
  end

  task automatic strobe(input logic [DW-1:0] d,
                        input logic [DW-1:0] x,
                        input bit keep);
    exp_t p;
    @(posedge clk);
    #1;
    in_data = d;
    in_valid = 1'b1;
    last_strobe = cyc + 1;
    if (keep) begin
      p.d = x;
      p.l = ((n_pushed % FL) == FL - 1);
      sb.push_back(p);
      n_pushed++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    gaps.delete();
    n_pushed = 0;
    ovf_cnt = 0;
    first_valid = -1;
    last_hs = -1;
    stall_prev = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_dropped", 32'(dropped), 0);
    chk("rst_frames_out", 32'(frames_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d left, expected 0",
               sb.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] cin  [8] = '{12'h000, 12'hFFF, 12'h7FF, 12'h800,
                              12'h123, 12'h456, 12'h9AB, 12'hC00};
  logic [DW-1:0] cexp [8] = '{12'h800, 12'h7FF, 12'hFFF, 12'h000,
                              12'h923, 12'hC56, 12'h1AB, 12'h400};

  initial begin
    // Reset and ready, with latency check
    rdy_mode = 1;
    do_reset();
    for (int i = 0; i < FL; i++)
      strobe(DW'(12'h800 + i), DW'(i), 1'b1);
    idle(1);
    drain();
    chk("first_latency", 32'(first_valid - last_strobe), 2);
    chk("t1_frames_out", 32'(frames_out), 1);

    // Conversion extremes
    do_reset();
    for (int i = 0; i < FL; i++)
      strobe(cin[i], cexp[i], 1'b1);
    idle(1);
    drain();
    chk("t2_frames_out", 32'(frames_out), 1);

    // Backpressure with random ready
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 2 * FL; i++)
      strobe(DW'(12'h300 + 7 * i),
             DW'(12'h300 + 7 * i) ^ 12'h800, 1'b1);
    idle(1);
    drain();
    chk("t3_frames_out", 32'(frames_out), 2);
    chk("t3_dropped", 32'(dropped), 0);

    // Overflow while the consumer stalls
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 20; i++)
      strobe(DW'(12'h050 + i), DW'(12'h050 + i) ^ 12'h800,
             i < 2 * FL);
    idle(4);
    chk("t4_ovf_pulses", 32'(ovf_cnt), 4);
    chk("t4_dropped", 32'(dropped), 4);
    chk("t4_stalled_valid", 32'(out_valid), 1);
    chk("t4_frames_stalled", 32'(frames_out), 0);
    rdy_mode = 1;
    drain();
    chk("t4_frames_out", 32'(frames_out), 2);
    chk("t4_dropped_end", 32'(dropped), 4);

    // Continuous streaming at the consumer rate
    do_reset();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < FL; i++)
        strobe(DW'(12'h100 + 16 * f + i),
               DW'(12'h100 + 16 * f + i) ^ 12'h800, 1'b1);
      idle(2);
    end
    drain();
    chk("t5_frames_out", 32'(frames_out), 4);
    chk("t5_dropped", 32'(dropped), 0);
    chk("t5_gap_count", 32'(gaps.size()), 3);
    foreach (gaps[i]) chk("t5_gap", 32'(gaps[i]), 2);

    // Mid-frame reset discards the partial frame
    do_reset();
    for (int i = 0; i < 5; i++)
      strobe(DW'(12'hA00 + i), '0, 1'b0);
    do_reset();
    for (int i = 0; i < FL; i++)
      strobe(DW'(12'h0F0 + i), DW'(12'h0F0 + i) ^ 12'h800, 1'b1);
    idle(1);
    drain();
    chk("t6_frames_out", 32'(frames_out), 1);
    chk("t6_dropped", 32'(dropped), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
